// File: rtl/ctrl_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_cmd_sequencer
//
// Serialises bursty control commands into a strict control stream for the
// application top. Commands {ctrl, hold} are buffered in a small FIFO. Each
// one is applied on ctrl_o for hold+1 cycles. The block then drives
// IDLE_CTRL and waits for flags_i[DONE_IDX] before it issues the next
// command.
//
// Optional feature macro: CTRL_SEQ_TIMEOUT_EN
//   When defined, a WAIT-cycle counter aborts a wait after TIMEOUT cycles
//   and sets the sticky err_o. When undefined, WAIT waits indefinitely and
//   err_o is tied low.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous active-low reset
//   cmd_valid_i  in   1        command present
//   cmd_ready_o  out  1        FIFO can accept (count != DEPTH)
//   cmd_ctrl_i   in   CTRL_W   control word of the command
//   cmd_hold_i   in   HOLD_W   hold value h (word applied h+1 cycles)
//   ctrl_o       out  CTRL_W   registered control word to the top
//   flags_i      in   FLAGS_W  flags from the top
//   cmd_done_o   out  1        one-cycle pulse when a command completes
//   busy_o       out  1        FSM not idle or FIFO non-empty
//   err_o        out  1        sticky timeout error
//   err_clr_i    in   1        clears err_o
// ---------------------------------------------------------------------------
module ctrl_cmd_sequencer #(
  parameter int                CTRL_W    = 8,
  parameter int                FLAGS_W   = 8,
  parameter int                HOLD_W    = 8,
  parameter int                DEPTH     = 4,
  parameter int                DONE_IDX  = 0,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = '0,
  parameter int                TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [CTRL_W-1:0]  cmd_ctrl_i,
  input  logic [HOLD_W-1:0]  cmd_hold_i,
  output logic [CTRL_W-1:0]  ctrl_o,
  input  logic [FLAGS_W-1:0] flags_i,
  output logic               cmd_done_o,
  output logic               busy_o,
  output logic               err_o,
  input  logic               err_clr_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // FIFO storage and control
  logic [CTRL_W-1:0] r_fifo_ctrl [DEPTH];
  logic [HOLD_W-1:0] r_fifo_hold [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [HOLD_W-1:0] w_head_hold;

  // FSM and output registers
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_cmd_done;
  logic              w_cmd_done_nxt;
  logic              w_done_flag;
  logic              w_leave_wait;

  // Only one flag bit and (in the default build) neither err_clr_i nor
  // TIMEOUT are functionally needed; fold them into a sink.
  logic              w_unused;
  localparam int     unused_timeout = TIMEOUT;
  assign w_unused = ^{flags_i, err_clr_i};

  assign w_empty     = (r_count == '0);
  assign cmd_ready_o = (r_count != CW'(DEPTH));
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_head_ctrl = r_fifo_ctrl[r_rd_ptr];
  assign w_head_hold = r_fifo_hold[r_rd_ptr];
  assign w_done_flag = flags_i[DONE_IDX];

  assign ctrl_o     = r_ctrl;
  assign cmd_done_o = r_cmd_done;
  assign busy_o     = (r_state != S_IDLE) || !w_empty;

`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait_cnt;
  logic [TW-1:0] w_wait_cnt_nxt;
  logic          w_err_set;
  logic          r_err;

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_ctrl_nxt     = r_ctrl;
    w_hold_nxt     = r_hold_cnt;
    w_cmd_done_nxt = 1'b0;
    w_pop          = 1'b0;
    w_leave_wait   = 1'b0;
`ifdef CTRL_SEQ_TIMEOUT_EN
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_set      = 1'b0;
`endif

    unique case (r_state)
      S_IDLE: begin
        w_ctrl_nxt = IDLE_CTRL;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_ctrl_nxt  = w_head_ctrl;
          w_hold_nxt  = w_head_hold;
          w_state_nxt = S_APPLY;
        end
      end

      S_APPLY: begin
        if (r_hold_cnt == '0) begin
          w_ctrl_nxt  = IDLE_CTRL;
          w_state_nxt = S_WAIT;
`ifdef CTRL_SEQ_TIMEOUT_EN
          w_wait_cnt_nxt = '0;
`endif
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end

      S_WAIT: begin
        w_ctrl_nxt = IDLE_CTRL;
        if (w_done_flag) begin
          w_cmd_done_nxt = 1'b1;
          w_leave_wait   = 1'b1;
        end
`ifdef CTRL_SEQ_TIMEOUT_EN
        // r_wait_cnt holds the number of completed WAIT cycles, so the
        // abort happens at the end of the TIMEOUT-th cycle.
        else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
          w_err_set    = 1'b1;
          w_leave_wait = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + TW'(1);
        end
`endif
        // Back-to-back: a queued command goes straight to APPLY, so the
        // WAIT cycle itself provides the IDLE_CTRL gap between words.
        if (w_leave_wait) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_ctrl_nxt  = w_head_ctrl;
            w_hold_nxt  = w_head_hold;
            w_state_nxt = S_APPLY;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_ctrl_nxt  = IDLE_CTRL;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control registers: state, outputs, FIFO pointers and count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ctrl     <= IDLE_CTRL;
      r_cmd_done <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_cmd_done <= w_cmd_done_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data registers: FIFO payload and hold counter (no reset needed; they are
  // always loaded before being used)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_ctrl[r_wr_ptr] <= cmd_ctrl_i;
      r_fifo_hold[r_wr_ptr] <= cmd_hold_i;
    end
    r_hold_cnt <= w_hold_nxt;
  end

`ifdef CTRL_SEQ_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Timeout counter and sticky error; a set in the same cycle as a clear wins
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    r_wait_cnt <= w_wait_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
module tb_ctrl_cmd_sequencer;

  localparam logic [7:0] IDLE_W = 8'h00;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready_o;
  logic [7:0] cmd_ctrl;
  logic [7:0] cmd_hold;
  logic [7:0] ctrl_o;
  logic [7:0] flags;
  logic       cmd_done_o;
  logic       busy_o;
  logic       err_o;
  logic       err_clr;

  ctrl_cmd_sequencer #(
    .CTRL_W(8), .FLAGS_W(8), .HOLD_W(8), .DEPTH(4), .DONE_IDX(0),
    .IDLE_CTRL(8'h00), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_ctrl_i(cmd_ctrl), .cmd_hold_i(cmd_hold),
    .ctrl_o(ctrl_o), .flags_i(flags),
    .cmd_done_o(cmd_done_o), .busy_o(busy_o),
    .err_o(err_o), .err_clr_i(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    int         len;
  } run_t;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] hold;
    int         delay;
    logic [7:0] exp_ctrl;
    int         exp_len;
  } vec_t;

  run_t exp_q[$];
  run_t obs_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: records each contiguous non-idle run of ctrl_o and done pulses.
  int         run_len = 0;
  logic [7:0] run_word = 8'h00;
  int         done_pulses = 0;
  int         done_wide = 0;
  logic       prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len   = 0;
      prev_done = 1'b0;
    end else begin
      if (ctrl_o != IDLE_W) begin
        if (run_len == 0) run_word = ctrl_o;
        run_len++;
      end else if (run_len != 0) begin
        obs_q.push_back('{w: run_word, len: run_len});
        run_len = 0;
      end
      if (cmd_done_o) begin
        done_pulses++;
        if (prev_done) done_wide++;
      end
      prev_done = cmd_done_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] h);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_ctrl  = c;
    cmd_hold  = h;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_idle_bound", 32'(ok), 32'd1);
  endtask

  task automatic check_runs();
    run_t e;
    run_t o;
    for (int i = 0; i < 2000 && obs_q.size() < exp_q.size(); i++) tick();
    chk("sb_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("sb_word", 32'(o.w), 32'(e.w));
      chk("sb_len", 32'(o.len), 32'(e.len));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int acc;
    int d0;
    int bad;
    bit ok;
    logic [7:0] seq_ctrl[6];
    logic       seq_done[6];

    vecs[0] = '{ctrl: 8'hA5, hold: 8'd3,  delay: 5, exp_ctrl: 8'hA5, exp_len: 4};
    vecs[1] = '{ctrl: 8'h01, hold: 8'd0,  delay: 0, exp_ctrl: 8'h01, exp_len: 1};
    vecs[2] = '{ctrl: 8'hFF, hold: 8'd7,  delay: 2, exp_ctrl: 8'hFF, exp_len: 8};
    vecs[3] = '{ctrl: 8'h3C, hold: 8'd20, delay: 1, exp_ctrl: 8'h3C, exp_len: 21};
    vecs[4] = '{ctrl: 8'h80, hold: 8'd1,  delay: 3, exp_ctrl: 8'h80, exp_len: 2};

    rst_n = 1'b0; cmd_valid = 1'b1; cmd_ctrl = 8'h99; cmd_hold = 8'd2;
    flags = 8'h00; err_clr = 1'b0;

    // Reset with a command presented: it must be discarded.
    repeat (3) tick();
    chk("rst_ctrl", 32'(ctrl_o), 32'(IDLE_W));
    chk("rst_done", 32'(cmd_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("rst_discard_busy", 32'(busy_o), 32'd0);
    chk("rst_discard_ctrl", 32'(ctrl_o), 32'(IDLE_W));

    // Table-driven single commands with done raised after a delay.
    for (int v = 0; v < 5; v++) begin
      d0 = done_pulses;
      send(vecs[v].ctrl, vecs[v].hold);
      exp_q.push_back('{w: vecs[v].exp_ctrl, len: vecs[v].exp_len});
      chk("lat_t", 32'(ctrl_o), 32'(IDLE_W));
      chk("lat_t_busy", 32'(busy_o), 32'd1);
      tick();
      chk("lat_t1", 32'(ctrl_o), 32'(vecs[v].exp_ctrl));
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (obs_q.size() > 0) begin
          ok = 1'b1;
          break;
        end
        tick();
      end
      chk("run_end_bound", 32'(ok), 32'd1);
      chk("wait_busy", 32'(busy_o), 32'd1);
      repeat (vecs[v].delay) tick();
      flags[0] = 1'b1;
      tick();
      flags[0] = 1'b0;
      chk("done_pulse", 32'(cmd_done_o), 32'd1);
      chk("busy_fall", 32'(busy_o), 32'd0);
      tick();
      chk("done_clear", 32'(cmd_done_o), 32'd0);
      chk("done_count", 32'(done_pulses - d0), 32'd1);
      check_runs();
    end

    // Fill: valid held high, done low; expect exactly 5 accepts.
    acc = 0;
    cmd_hold = 8'd50;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = 1'b1;
      cmd_ctrl  = 8'h40 + 8'(acc);
      if (cmd_ready_o) begin
        exp_q.push_back('{w: 8'h40 + 8'(acc), len: 51});
        acc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("fill_accepts", 32'(acc), 32'd5);
    chk("fill_ready", 32'(cmd_ready_o), 32'd0);
    chk("fill_head", 32'(ctrl_o), 32'h40);
    d0 = done_pulses;
    flags[0] = 1'b1;
    wait_idle(1000);
    flags[0] = 1'b0;
    tick();
    chk("fill_pulses", 32'(done_pulses - d0), 32'd5);
    check_runs();

    // Back-to-back with done held high.
    flags[0] = 1'b1;
    seq_ctrl = '{8'h11, 8'h00, 8'h22, 8'h22, 8'h00, 8'h00};
    seq_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    send(8'h11, 8'd0);
    exp_q.push_back('{w: 8'h11, len: 1});
    send(8'h22, 8'd1);
    exp_q.push_back('{w: 8'h22, len: 2});
    for (int k = 0; k < 6; k++) begin
      chk("b2b_ctrl", 32'(ctrl_o), 32'(seq_ctrl[k]));
      chk("b2b_done", 32'(cmd_done_o), 32'(seq_done[k]));
      tick();
    end
    flags[0] = 1'b0;
    check_runs();

    // Reset during APPLY with two entries queued.
    d0 = done_pulses;
    send(8'h71, 8'd30);
    send(8'h72, 8'd5);
    send(8'h73, 8'd5);
    tick();
    chk("pre_rst_ctrl", 32'(ctrl_o), 32'h71);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ctrl", 32'(ctrl_o), 32'(IDLE_W));
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
    flags[0] = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (cmd_done_o || busy_o || ctrl_o != IDLE_W) bad++;
    end
    flags[0] = 1'b0;
    chk("post_rst_quiet", 32'(bad), 32'd0);
    chk("post_rst_pulses", 32'(done_pulses - d0), 32'd0);
    chk("post_rst_runs", 32'(obs_q.size()), 32'd0);
    exp_q.delete();
    obs_q.delete();

`ifdef CTRL_SEQ_TIMEOUT_EN
    // Timeout after 16 WAIT cycles with done low.
    d0 = done_pulses;
    send(8'h5A, 8'd0);
    exp_q.push_back('{w: 8'h5A, len: 1});
    tick();
    tick();
    repeat (15) tick();
    chk("to_before", 32'(err_o), 32'd0);
    tick();
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_no_pulse", 32'(done_pulses - d0), 32'd0);
    check_runs();
    flags[0] = 1'b1;
    send(8'h6B, 8'd0);
    exp_q.push_back('{w: 8'h6B, len: 1});
    wait_idle(100);
    flags[0] = 1'b0;
    chk("to_next_pulse", 32'(done_pulses - d0), 32'd1);
    chk("to_sticky", 32'(err_o), 32'd1);
    check_runs();
    err_clr = 1'b1;
    tick();
    chk("to_clear", 32'(err_o), 32'd0);
    // Clear held through a second timeout: the set must win.
    send(8'h6C, 8'd0);
    exp_q.push_back('{w: 8'h6C, len: 1});
    tick();
    tick();
    repeat (15) tick();
    chk("to2_before", 32'(err_o), 32'd0);
    tick();
    chk("to2_set_wins", 32'(err_o), 32'd1);
    tick();
    chk("to2_cleared", 32'(err_o), 32'd0);
    err_clr = 1'b0;
    check_runs();
`else
    // Without the timeout feature WAIT waits indefinitely and err_o stays 0.
    d0 = done_pulses;
    send(8'h5B, 8'd0);
    exp_q.push_back('{w: 8'h5B, len: 1});
    repeat (40) tick();
    chk("nto_busy", 32'(busy_o), 32'd1);
    chk("nto_no_pulse", 32'(done_pulses - d0), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("nto_err", 32'(err_o), 32'd0);
    flags[0] = 1'b1;
    tick();
    tick();
    flags[0] = 1'b0;
    chk("nto_release", 32'(busy_o), 32'd0);
    check_runs();
`endif

    // Wrap-around: 10 commands streamed through the 4-entry FIFO.
    flags[0] = 1'b1;
    acc = 0;
    for (int c = 0; c < 500 && acc < 10; c++) begin
      cmd_valid = 1'b1;
      cmd_ctrl  = 8'hB0 + 8'(acc);
      cmd_hold  = 8'(acc % 3);
      if (cmd_ready_o) begin
        exp_q.push_back('{w: 8'hB0 + 8'(acc), len: (acc % 3) + 1});
        acc++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("wrap_accepts", 32'(acc), 32'd10);
    wait_idle(500);
    flags[0] = 1'b0;
    tick();
    check_runs();

    chk("done_width", 32'(done_wide), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
